// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the N-port SDRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sdram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_t;

    localparam int MAX_PORTS = 16;

    // Arbitration mode as seen by the pick logic
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Controller bus widths
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int WR_W   = 2;

endpackage

// File: rtl/sdram_ctrl_if.sv
// SDRAM controller request/completion bundle.
// Latency: n/a (wiring only).
// Backpressure: rdy from the subordinate side qualifies rd/wr.
// Modports: man drives rd/wr/addr/write_data and receives rdy/rvalid/wvalid/error/read_data;
//           sub is the mirror image.
interface sdram_ctrl_if;
    logic                              rd;
    logic [sdram_arb_pkg::WR_W-1:0]    wr;
    logic [sdram_arb_pkg::ADDR_W-1:0]  addr;
    logic [sdram_arb_pkg::DATA_W-1:0]  write_data;
    logic                              rdy;
    logic                              rvalid;
    logic                              wvalid;
    logic                              error;
    logic [sdram_arb_pkg::DATA_W-1:0]  read_data;

    modport man (
        output rd, wr, addr, write_data,
        input  rdy, rvalid, wvalid, error, read_data
    );

    modport sub (
        input  rd, wr, addr, write_data,
        output rdy, rvalid, wvalid, error, read_data
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// Rotating priority encoder: first requester at or after the start index, wrapping.
// Latency: combinational.
// Backpressure: none; valid=0 when nothing requests.
// Ports: req (one bit per port), ptr (rotation start), mode (fixed/RR) -> gnt index, valid.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             mode,
    output logic [PTR_W-1:0] gnt,
    output logic             valid
);

    logic [PTR_W-1:0] start;

    // Fixed priority is just rotation starting at port 0
    assign start = (mode == ARB_RR) ? ptr : '0;

    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return PTR_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester wins
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrapIdx(start, k)]) begin
                gnt   = wrapIdx(start, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arb_n.sv
// N-port arbiter in front of one SDRAM controller, single outstanding transaction, with watchdog.
// Latency: request->controller 0 cycles in IDLE; completion->owner 0 cycles.
// Backpressure: only the granted port sees rdy (= controller rdy) in IDLE; all ports stalled while BUSY.
// Ports: clk, rst (sync active-high); ctrl_if (to controller); port_if[NPORTS] (clients);
//        busy, owner, timeout_pulse status outputs.
module sdram_arb_n
    import sdram_arb_pkg::*;
#(
    parameter  int NPORTS  = 4,
    parameter  int RR_MODE = 1,
    parameter  int TIMEOUT = 1024,
    localparam int OWNER_W = $clog2(NPORTS)
) (
    input  logic               clk,
    input  logic               rst,
    sdram_ctrl_if.man          ctrl_if,
    sdram_ctrl_if.sub          port_if [NPORTS],
    output logic               busy,
    output logic [OWNER_W-1:0] owner,
    output logic               timeout_pulse
);

    // Counter wide enough to hold TIMEOUT-1 plus saturation headroom
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ARB_MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    arbState_t          state, nextState;
    logic [OWNER_W-1:0] rrPtr;
    logic [WD_W-1:0]    wdCnt;

    logic [NPORTS-1:0]  req;
    logic               anyReq;
    logic [OWNER_W-1:0] gnt;
    logic               issue;
    logic               txnEnd;
    logic               wdFire;
    logic               done;
    logic [OWNER_W-1:0] nextPtr;

    logic               pRd    [NPORTS];
    logic [WR_W-1:0]    pWr    [NPORTS];
    logic [ADDR_W-1:0]  pAddr  [NPORTS];
    logic [DATA_W-1:0]  pWdat  [NPORTS];

    assign done = ctrl_if.rvalid | ctrl_if.wvalid | ctrl_if.error;

    sdram_rr_pick #(.N(NPORTS)) uPick (
        .req   (req),
        .ptr   (rrPtr),
        .mode  (ARB_MODE),
        .gnt   (gnt),
        .valid (anyReq)
    );

    // Per-port gather of requests and scatter of responses
    for (genvar g = 0; g < NPORTS; g++) begin : gPort
        localparam logic [OWNER_W-1:0] IDX = OWNER_W'(g);
        logic ownerHit;

        assign req[g]   = port_if[g].rd | (port_if[g].wr != '0);
        assign pRd[g]   = port_if[g].rd;
        assign pWr[g]   = port_if[g].wr;
        assign pAddr[g] = port_if[g].addr;
        assign pWdat[g] = port_if[g].write_data;

        assign ownerHit = (state == BUSY) && (owner == IDX);

        assign port_if[g].rdy       = (state == IDLE) && anyReq && (gnt == IDX) && ctrl_if.rdy;
        assign port_if[g].rvalid    = ownerHit & ctrl_if.rvalid;
        assign port_if[g].wvalid    = ownerHit & ctrl_if.wvalid;
        assign port_if[g].error     = ownerHit & (ctrl_if.error | wdFire);
        assign port_if[g].read_data = (ownerHit && done) ? ctrl_if.read_data : '0;
    end

    // Controller request mux: only in IDLE and only with a live grant
    assign ctrl_if.rd         = (state == IDLE && anyReq) ? pRd[gnt]   : 1'b0;
    assign ctrl_if.wr         = (state == IDLE && anyReq) ? pWr[gnt]   : '0;
    assign ctrl_if.addr       = (state == IDLE && anyReq) ? pAddr[gnt] : '0;
    assign ctrl_if.write_data = (state == IDLE && anyReq) ? pWdat[gnt] : '0;

    assign nextPtr = (owner == OWNER_W'(NPORTS - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        nextState = state;
        issue     = 1'b0;
        txnEnd    = 1'b0;
        wdFire    = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq && ctrl_if.rdy) begin
                    issue     = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                // A real completion on the last watchdog cycle wins over the timeout
                if (done) begin
                    txnEnd    = 1'b1;
                    nextState = IDLE;
                end else if ((TIMEOUT != 0) && (wdCnt == WD_LAST)) begin
                    wdFire    = 1'b1;
                    txnEnd    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            rrPtr <= '0;
            wdCnt <= '0;
        end else begin
            state <= nextState;
            if (issue) begin
                owner <= gnt;
                wdCnt <= '0;
            end else if (state == BUSY && wdCnt != '1) begin
                wdCnt <= wdCnt + 1'b1;
            end
            if (txnEnd && ARB_MODE == ARB_RR) begin
                rrPtr <= nextPtr;
            end
        end
    end

    assign busy          = (state == BUSY);
    assign timeout_pulse = wdFire;

endmodule

// File: tb/tb_sdram_arb_n.sv
// Directed bench: one fixed-priority and one round-robin arbiter, both with TIMEOUT=8.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_sdram_arb_n;

    localparam int F = 0;   // fixed-priority instance
    localparam int R = 1;   // round-robin instance

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus
    logic        pRd   [2][4];
    logic [1:0]  pWr   [2][4];
    logic [23:0] pAddr [2][4];
    logic [15:0] pWdat [2][4];
    logic        cRdy  [2];
    logic        cRv   [2];
    logic        cWv   [2];
    logic        cErr  [2];
    logic [15:0] cRdat [2];

    // Observations
    wire         oRdy  [2][4];
    wire         oRv   [2][4];
    wire         oWv   [2][4];
    wire         oErr  [2][4];
    wire [15:0]  oRdat [2][4];
    wire         cORd  [2];
    wire [1:0]   cOWr  [2];
    wire [23:0]  cOAddr[2];
    wire [15:0]  cOWdat[2];
    wire         busy  [2];
    wire [1:0]   owner [2];
    wire         tp    [2];

    int checks   = 0;
    int failures = 0;

    for (genvar m = 0; m < 2; m++) begin : gDut
        sdram_ctrl_if ctrl ();
        sdram_ctrl_if ports [4] ();

        assign ctrl.rdy       = cRdy[m];
        assign ctrl.rvalid    = cRv[m];
        assign ctrl.wvalid    = cWv[m];
        assign ctrl.error     = cErr[m];
        assign ctrl.read_data = cRdat[m];
        assign cORd[m]   = ctrl.rd;
        assign cOWr[m]   = ctrl.wr;
        assign cOAddr[m] = ctrl.addr;
        assign cOWdat[m] = ctrl.write_data;

        for (genvar p = 0; p < 4; p++) begin : gP
            assign ports[p].rd         = pRd[m][p];
            assign ports[p].wr         = pWr[m][p];
            assign ports[p].addr       = pAddr[m][p];
            assign ports[p].write_data = pWdat[m][p];
            assign oRdy[m][p]  = ports[p].rdy;
            assign oRv[m][p]   = ports[p].rvalid;
            assign oWv[m][p]   = ports[p].wvalid;
            assign oErr[m][p]  = ports[p].error;
            assign oRdat[m][p] = ports[p].read_data;
        end

        sdram_arb_n #(.NPORTS(4), .RR_MODE(m), .TIMEOUT(8)) dut (
            .clk           (clk),
            .rst           (rst),
            .ctrl_if       (ctrl),
            .port_if       (ports),
            .busy          (busy[m]),
            .owner         (owner[m]),
            .timeout_pulse (tp[m])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            cRdy[m] = 1'b0; cRv[m] = 1'b0; cWv[m] = 1'b0; cErr[m] = 1'b0; cRdat[m] = '0;
            for (int p = 0; p < 4; p++) begin
                pRd[m][p] = 1'b0; pWr[m][p] = '0;
                pAddr[m][p] = 24'(p * 'h100); pWdat[m][p] = '0;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // ---------------- reset state ----------------
        chk("rst_busy", busy[F], 0);
        chk("rst_owner", owner[F], 0);
        chk("rst_tp", tp[F], 0);
        chk("rst_ctrl_rd", cORd[F], 0);
        chk("rst_ctrl_addr", cOAddr[F], 0);
        for (int p = 0; p < 4; p++) begin
            chk("rst_port_rdy", oRdy[F][p], 0);
            chk("rst_port_rdat", oRdat[R][p], 0);
        end

        // ---------------- fixed priority: ports 1 and 3 read ----------------
        @(negedge clk);
        cRdy[F] = 1'b1; cRdy[R] = 1'b1;
        pRd[F][1] = 1'b1; pRd[F][3] = 1'b1;
        #1;
        chk("fix_rdy1", oRdy[F][1], 1);
        chk("fix_rdy3", oRdy[F][3], 0);
        chk("fix_ctrl_rd", cORd[F], 1);
        chk("fix_ctrl_addr", cOAddr[F], 24'h100);
        @(negedge clk);
        pRd[F][1] = 1'b0;
        #1;
        chk("fix_busy", busy[F], 1);
        chk("fix_owner", owner[F], 1);
        chk("fix_busy_ctrl_rd", cORd[F], 0);
        chk("fix_busy_rdy3", oRdy[F][3], 0);
        @(negedge clk);
        cRv[F] = 1'b1; cRdat[F] = 16'hA5A5;
        #1;
        chk("fix_rv1", oRv[F][1], 1);
        chk("fix_rdat1", oRdat[F][1], 16'hA5A5);
        chk("fix_rv3", oRv[F][3], 0);
        chk("fix_rdat3", oRdat[F][3], 0);
        chk("fix_rv0", oRv[F][0], 0);
        @(negedge clk);
        cRv[F] = 1'b0;
        #1;
        chk("fix_idle_busy", busy[F], 0);
        chk("fix_next_rdy3", oRdy[F][3], 1);
        chk("fix_next_addr", cOAddr[F], 24'h300);
        @(negedge clk);
        pRd[F][3] = 1'b0;
        #1;
        chk("fix_owner3", owner[F], 3);
        @(negedge clk);
        cRv[F] = 1'b1; cRdat[F] = 16'h1234;
        #1;
        chk("fix_rdat3b", oRdat[F][3], 16'h1234);
        @(negedge clk);
        cRv[F] = 1'b0;

        // ---------------- watchdog: TIMEOUT=8, no completion ----------------
        pWr[F][2] = 2'b11; pWdat[F][2] = 16'hBEEF;
        #1;
        chk("wd_ctrl_wr", cOWr[F], 2'b11);
        chk("wd_ctrl_wdat", cOWdat[F], 16'hBEEF);
        chk("wd_rdy2", oRdy[F][2], 1);
        @(negedge clk);                     // BUSY cycle 1
        pWr[F][2] = '0; pWdat[F][2] = '0;
        for (int c = 1; c < 8; c++) begin
            #1;
            chk("wd_early_err", oErr[F][2], 0);
            chk("wd_early_tp", tp[F], 0);
            @(negedge clk);
        end
        #1;                                 // BUSY cycle 8
        chk("wd_err2", oErr[F][2], 1);
        chk("wd_tp", tp[F], 1);
        chk("wd_err0", oErr[F][0], 0);
        chk("wd_busy_fire", busy[F], 1);
        @(negedge clk);
        #1;
        chk("wd_after_busy", busy[F], 0);
        chk("wd_after_tp", tp[F], 0);
        chk("wd_after_err", oErr[F][2], 0);
        @(negedge clk);
        cRv[F] = 1'b1; cRdat[F] = 16'h5555;
        #1;
        chk("stray_rv2", oRv[F][2], 0);
        chk("stray_rdat2", oRdat[F][2], 0);
        chk("stray_rv0", oRv[F][0], 0);
        @(negedge clk);
        cRv[F] = 1'b0;

        // ---------------- completion and timeout in the same cycle ----------------
        pWr[F][0] = 2'b01;
        @(negedge clk);                     // BUSY cycle 1
        pWr[F][0] = '0;
        #1;
        chk("same_owner0", owner[F], 0);
        repeat (7) @(negedge clk);          // BUSY cycle 8
        cWv[F] = 1'b1;
        #1;
        chk("same_wv0", oWv[F][0], 1);
        chk("same_err0", oErr[F][0], 0);
        chk("same_tp", tp[F], 0);
        @(negedge clk);
        cWv[F] = 1'b0;
        #1;
        chk("same_after_busy", busy[F], 0);

        // ---------------- reset while BUSY ----------------
        pRd[F][1] = 1'b1;
        @(negedge clk);
        pRd[F][1] = 1'b0;
        #1;
        chk("mrst_owner1", owner[F], 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cRv[F] = 1'b1; cRdat[F] = 16'h7777;
        #1;
        chk("mrst_busy", busy[F], 0);
        chk("mrst_owner", owner[F], 0);
        for (int p = 0; p < 4; p++) begin
            chk("mrst_rdy", oRdy[F][p], 0);
            chk("mrst_rv", oRv[F][p], 0);
            chk("mrst_err", oErr[F][p], 0);
            chk("mrst_rdat", oRdat[F][p], 0);
        end
        @(negedge clk);
        cRv[F] = 1'b0;
        pRd[F][2] = 1'b1;
        #1;
        chk("mrst_rdy2", oRdy[F][2], 1);
        @(negedge clk);
        pRd[F][2] = 1'b0;
        #1;
        chk("mrst_owner2", owner[F], 2);
        chk("mrst_busy2", busy[F], 1);
        @(negedge clk);
        cRv[F] = 1'b1;
        #1;
        chk("mrst_rv2", oRv[F][2], 1);
        @(negedge clk);
        cRv[F] = 1'b0;

        // ---------------- round robin: all ports request continuously ----------------
        for (int p = 0; p < 4; p++) pRd[R][p] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_rdy", oRdy[R][k % 4], 1);
            chk("rr_addr", cOAddr[R], 24'((k % 4) * 'h100));
            @(negedge clk);
            cRv[R] = 1'b1; cRdat[R] = 16'(k);
            #1;
            chk("rr_owner", owner[R], k % 4);
            chk("rr_rv", oRv[R][k % 4], 1);
            @(negedge clk);
            cRv[R] = 1'b0;
        end
        for (int p = 0; p < 4; p++) pRd[R][p] = 1'b0;

        // ---------------- round robin wrap: rr_ptr 1 -> 3 via port 2 ----------------
        pRd[R][2] = 1'b1;
        #1;
        chk("wrap_pre_rdy2", oRdy[R][2], 1);
        @(negedge clk);
        pRd[R][2] = 1'b0;
        cRv[R] = 1'b1;
        #1;
        chk("wrap_pre_owner", owner[R], 2);
        @(negedge clk);
        cRv[R] = 1'b0;
        pRd[R][0] = 1'b1; pRd[R][2] = 1'b1;
        #1;
        chk("wrap_rdy0", oRdy[R][0], 1);
        chk("wrap_rdy2", oRdy[R][2], 0);
        @(negedge clk);
        cRv[R] = 1'b1;
        #1;
        chk("wrap_owner0", owner[R], 0);
        @(negedge clk);
        cRv[R] = 1'b0;
        #1;
        chk("wrap_next_rdy2", oRdy[R][2], 1);
        chk("wrap_next_rdy0", oRdy[R][0], 0);
        @(negedge clk);
        cRv[R] = 1'b1;
        #1;
        chk("wrap_owner2", owner[R], 2);
        @(negedge clk);
        cRv[R] = 1'b0;
        pRd[R][0] = 1'b0; pRd[R][2] = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
